// File: rtl/bcd_timer_pkg.sv
// Shared types, seven-segment table and sizing helpers for the BCD timer.
package bcd_timer_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low patterns with bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_BLANK = 7'h7f;

  function automatic logic [6:0] seg_decode(bcd_t v);
    if (v <= 4'd9) return SEG_LUT[v];
    return SEG_BLANK;
  endfunction

  function automatic int unsigned presc_width(int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_timer_digit.sv
// One BCD decade cell: up/down count with carry/borrow out, clear and sanitised load.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic step_in,
  input  logic up,
  input  logic clr,
  input  logic load,
  input  bcd_t load_d,
  output bcd_t q,
  output logic carry_out
);

  bcd_t q_q, q_d;

  assign q         = q_q;
  assign carry_out = step_in & (up ? (q_q == 4'd9) : (q_q == 4'd0));

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (load) begin
      q_d = (load_d > 4'd9) ? 4'd0 : load_d;
    end else if (step_in) begin
      if (up) q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
      else    q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 4'd0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/bcd_timer.sv
// Prescaled multi-digit BCD up/down timer with wrap pulse and seven-segment outputs.
module bcd_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned DIGITS  = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  up,
  output logic                  tick,
  output logic                  wrap,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = presc_width(DIV);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("bcd_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_timer: DIGITS must be in 1..8");
  end

  logic [PW-1:0] p_q, p_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          tc;
  logic [DIGITS:0] carry;

  always_comb begin
    tc  = (p_q == PW'(DIV - 1));
    p_d = p_q;
    if (clr || load) p_d = '0;
    else if (en)     p_d = tc ? '0 : p_q + 1'b1;
  end

  // Terminal count only steps the chain when no clear/load pre-empts it.
  assign carry[0] = en & tc & ~clr & ~load;
  assign tick_d   = carry[0];
  assign wrap_d   = carry[DIGITS];

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit u_digit (
      .clk       (CLOCK_50),
      .rst_n     (reset_n),
      .step_in   (carry[d]),
      .up        (up),
      .clr       (clr),
      .load      (load),
      .load_d    (load_val[4*d +: 4]),
      .q         (bcd[4*d +: 4]),
      .carry_out (carry[d+1])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      p_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) seg[7*i +: 7] = seg_decode(bcd_t'(bcd[4*i +: 4]));
  end

endmodule

// File: tb/tb_bcd_timer.sv
// Directed self-checking bench for bcd_timer with DIV=10 and two digits.
module tb_bcd_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, clr, load, up;
  logic [7:0]  load_val;
  logic        tick, wrap;
  logic [7:0]  bcd;
  logic [13:0] seg;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG5 = 7'b0010010;
  localparam logic [6:0] SEG7 = 7'b1111000;

  bcd_timer #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .up       (up),
    .tick     (tick),
    .wrap     (wrap),
    .bcd      (bcd),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps until tick is seen or the budget runs out; cycles = edges consumed.
  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (tick) break;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    int ticks, last, gap_err, cycles;
    reset_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b1; load_val = 8'h00;
    #1;
    chk("reset_bcd",  bcd,  8'h00);
    chk("reset_tick", tick, 1'b0);
    chk("reset_wrap", wrap, 1'b0);
    chk("reset_seg",  seg,  {SEG0, SEG0});

    #21;
    reset_n = 1'b1;
    en = 1'b1;
    ticks = 0; last = 0; gap_err = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (c == 9)  chk("no_tick_c9", tick, 1'b0);
      if (c == 10) begin
        chk("first_tick_c10", tick, 1'b1);
        chk("bcd_after_first", bcd, 8'h01);
      end
      if (tick) begin
        if (c - last != 10) gap_err++;
        last = c;
        ticks++;
      end
    end
    chk("tick_count_100", ticks, 10);
    chk("tick_gaps", gap_err, 0);
    chk("bcd_after_100", bcd, 8'h10);
    chk("seg_10", seg, {SEG1, SEG0});

    do_load(8'h98);
    chk("load_98", bcd, 8'h98);
    wait_tick(20, cycles);
    chk("up_period", cycles, 10);
    chk("up_bcd_99", bcd, 8'h99);
    chk("up_wrap_99", wrap, 1'b0);
    wait_tick(20, cycles);
    chk("up_bcd_00", bcd, 8'h00);
    chk("up_wrap_00", wrap, 1'b1);
    cyc(1);
    chk("wrap_one_cycle", wrap, 1'b0);
    chk("tick_one_cycle", tick, 1'b0);

    up = 1'b0;
    do_load(8'h10);
    wait_tick(20, cycles);
    chk("dn_bcd_09", bcd, 8'h09);
    chk("dn_wrap_09", wrap, 1'b0);
    wait_tick(20, cycles);
    chk("dn_bcd_08", bcd, 8'h08);
    do_load(8'h00);
    wait_tick(20, cycles);
    chk("dn_bcd_99", bcd, 8'h99);
    chk("dn_wrap_99", wrap, 1'b1);

    up = 1'b1;
    do_load(8'h00);
    cyc(4);
    en = 1'b0;
    ticks = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      if (tick) ticks++;
    end
    chk("pause_no_tick", ticks, 0);
    chk("pause_hold_bcd", bcd, 8'h00);
    en = 1'b1;
    wait_tick(20, cycles);
    chk("resume_period", cycles, 6);
    chk("resume_bcd", bcd, 8'h01);

    cyc(9);
    clr = 1'b1; load = 1'b1; load_val = 8'h55;
    cyc(1);
    clr = 1'b0; load = 1'b0;
    chk("prio_bcd", bcd, 8'h00);
    chk("prio_tick", tick, 1'b0);
    chk("prio_wrap", wrap, 1'b0);
    do_load(8'hAF);
    chk("load_invalid_af", bcd, 8'h00);
    do_load(8'h3C);
    chk("load_invalid_3c", bcd, 8'h30);

    do_load(8'h57);
    chk("bcd_57", bcd, 8'h57);
    chk("seg_57", seg, {SEG5, SEG7});
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_bcd", bcd, 8'h00);
    chk("async_tick", tick, 1'b0);
    chk("async_seg", seg, {SEG0, SEG0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised real-time decade counter: a prescaler divides the board clock down to a tick rate, and a cascaded chain of DIGITS BCD digit cells counts ticks up or down. It adds synchronous clear, parallel load, a direction select and a wrap pulse. Each digit is decoded to an active-low seven-segment pattern. It sits between the board switches/keys and the HEX displays, and is the generalised successor of the single-digit 1 Hz seconds counter.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 1: count rate; DIV = CLK_HZ/TICK_HZ, elaboration error if DIV < 2 or not an integer.
- DIGITS, 4: number of BCD digits (1..8).
- CLOCK_50  in  1  system clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes prescaler and count.
- clr  in  1  synchronous clear of prescaler and count.
- load  in  1  synchronous parallel load.
- load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0].
- up  in  1  direction: 1 = increment, 0 = decrement.
- tick  out  1  one-cycle pulse on each count step.
- wrap  out  1  one-cycle pulse when the whole count wraps.
- bcd  out  4*DIGITS  current count, digit 0 in [3:0].
- seg  out  7*DIGITS  active-low segments, digit d in [7d+6:7d], bit 7d = segment a … 7d+6 = segment g.

## Operation
- Reset (async assert, sync release): prescaler p=0, bcd=0, tick=0, wrap=0; seg shows "0" on every digit (7'b0000001 per digit, a..g order).
- Priority each edge: clr > load > en step > hold.
- clr=1: p<=0, bcd<=0, tick<=0, wrap<=0.
- load=1 (clr=0): p<=0, bcd<=load_val; any load digit >9 loads as 0; tick/wrap <=0.
- en=1, neither clr nor load:
  - p<DIV-1: p<=p+1.
  - p==DIV-1: p<=0, tick<=1, and bcd steps once.
- Step up:
  - digit 0 increments; digit 9 goes to 0 and carries to the next digit.
  - Carry ripples combinationally across all digits within the same cycle.
  - All-9s goes to all-0s with wrap<=1.
- Step down:
  - digit 0 decrements; digit 0 goes to 9 and borrows from the next digit.
  - All-0s goes to all-9s with wrap<=1.
- en=0: p and bcd hold; tick=0, wrap=0. Prescaler resumes from its held value when en returns, so no partial period is lost or restarted.
- up may change at any time; it is sampled only on step edges. No prescaler effect.
- seg is a combinational decode of registered bcd; no glitch-free guarantee required.

## Timing
- tick and wrap are registered, high for exactly one cycle, and coincide with the cycle the new bcd is visible.
- With en held high from reset release, the first tick occurs DIV edges after the first active edge; thereafter the tick period is exactly DIV cycles.
- Latency:
  - clr/load: bcd updated 1 cycle after the edge sampling them.
  - seg follows bcd in the same cycle.
- clr or load coinciding with p==DIV-1: clr/load wins, and no tick or wrap is produced.
- reset_n asserted mid-period: immediate return to reset values regardless of the clock.
- Critical path: DIGITS-deep carry chain plus prescaler compare; it must close at 50 MHz for DIGITS=8.

## Structure
- Package bcd_timer_pkg holds:
  - typedef bcd_t (logic [3:0]).
  - Constant array SEG_LUT[0:9] of active-low patterns, plus blank for invalid values.
  - Function seg_decode(bcd_t).
  - Helper function clog2-based prescaler width (PW = $clog2(DIV)).
- Sub-module bcd_digit, instantiated DIGITS times via generate:
  - Inputs: step_in, up, clr, load, load_d.
  - Outputs: q, carry_out.
  - carry_out = step_in & (up ? q==9 : q==0).
  - Digit d's step_in = carry_out of digit d-1; digit 0's step_in is the prescaler terminal count.
  - wrap = carry_out of the top digit, registered.

## Test plan
- Bench params CLK_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=2.
- Reset then en=1 for 100 cycles, up=1 -> tick every 10 cycles, first tick on cycle 10; bcd 00→10; seg digit0 = "0" pattern.
- Counting up across the top: load 8'h98, then run 2 ticks -> bcd 99 then 00; wrap high exactly with 00, one cycle.
- Down with borrow: load 8'h10, up=0, run 2 ticks -> bcd 09 then 08; load 8'h00, one tick -> bcd 99 with wrap=1.
- Pause: en=0 for 7 cycles after p=4 -> no tick; resume -> next tick 6 cycles later, not 10.
- Priority: assert clr and load together on a terminal-count cycle -> bcd 00, tick=0, wrap=0. Load 8'hAF -> bcd 00 (invalid digits forced to 0).
- Async reset: drop reset_n between clock edges at bcd=57 -> bcd=00, tick=0 immediately, before the next edge.
